// File: rtl/zero_branch_ctrl_pkg.sv
// Shared definitions for the zero-compare branch controller.
//   br_op_e    : zero-compare branch opcodes as carried on i_br_op
//   state_e    : controller FSM states
//   br_taken_f : maps an opcode and the judge flags to a taken decision
package zero_branch_ctrl_pkg;

  typedef enum logic [1:0] {
    BR_BGEZ = 2'b00,
    BR_BGTZ = 2'b01,
    BR_BLEZ = 2'b10,
    BR_BLTZ = 2'b11
  } br_op_e;

  typedef enum logic {
    StIdle = 1'b0,
    StWait = 1'b1
  } state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  // The judge only reports "rs >= 0" and "rs > 0"; the other two ops are their complements.
  function automatic logic br_taken_f(input br_op_e op, input logic zbgez, input logic zbgtz);
    logic taken;
    unique case (op)
      BR_BGEZ: taken = zbgez;
      BR_BGTZ: taken = zbgtz;
      BR_BLEZ: taken = !zbgtz;
      BR_BLTZ: taken = !zbgez;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/zero_branch_ctrl_br_target_calc.sv
// Branch target adder: target = pc + 4 + sign_extend(offset) * 4, 32-bit wrap.
//   i_pc     : PC of the branch instruction
//   i_offset : signed word offset from the instruction
//   o_target : redirect address
module zero_branch_ctrl_br_target_calc (
  input  logic [31:0] i_pc,
  input  logic [15:0] i_offset,
  output logic [31:0] o_target
);

  logic [31:0] w_disp;

  assign w_disp   = {{14{i_offset[15]}}, i_offset, 2'b00};
  assign o_target = i_pc + 32'd4 + w_disp;

endmodule

// File: rtl/zero_branch_ctrl.sv
// ID-stage controller for bgez/bgtz/blez/bltz. Waits for a final rs operand, strobes one
// judge select in the evaluation cycle, converts the returned flags into a taken decision,
// and owns the fetch PC plus saturating branch statistics.
//   i_clk, i_rst           : clock, synchronous active-high reset
//   i_stall_in             : global freeze; holds every piece of state
//   i_br_valid, i_br_op,
//   i_br_offset, i_id_pc   : branch presented by ID
//   i_busA_ready, i_busA   : rs operand and its readiness
//   o_j_busA, o_j_*        : operand and one-hot op select towards the judge
//   i_zbgez, i_zbgtz       : judge flags, meaningful only while a select is asserted
//   o_pc                   : fetch PC
//   o_flush_if, o_br_taken : registered single-cycle pulses following a taken resolution
//   o_id_stall             : hold ID while waiting for the operand
//   o_cnt_total/taken      : saturating resolved / taken counters
module zero_branch_ctrl
  import zero_branch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter bit          DELAY_SLOT = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_stall_in,
  input  logic             i_br_valid,
  input  logic [1:0]       i_br_op,
  input  logic [15:0]      i_br_offset,
  input  logic [31:0]      i_id_pc,
  input  logic             i_busA_ready,
  input  logic [31:0]      i_busA,
  output logic [31:0]      o_j_busA,
  output logic             o_j_bgez,
  output logic             o_j_bgtz,
  output logic             o_j_blez,
  output logic             o_j_bltz,
  input  logic             i_zbgez,
  input  logic             i_zbgtz,
  output logic [31:0]      o_pc,
  output logic             o_flush_if,
  output logic             o_id_stall,
  output logic             o_br_taken,
  output logic [CNT_W-1:0] o_cnt_total,
  output logic [CNT_W-1:0] o_cnt_taken
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e           r_state, w_state_next;
  br_op_e           r_op;
  logic [15:0]      r_off;
  logic [31:0]      r_id_pc;
  logic [31:0]      r_pc;
  logic             r_br_taken, r_flush_if;
  logic [CNT_W-1:0] r_cnt_total, r_cnt_taken;

  logic             w_waiting, w_eval, w_latch, w_taken, w_seq_adv;
  br_op_e           w_op;
  logic [15:0]      w_off;
  logic [31:0]      w_br_pc, w_target;

  assign w_waiting = (r_state == StWait);

  // While waiting, the fields captured on entry are authoritative; ID inputs may have moved.
  assign w_op    = w_waiting ? r_op    : br_op_e'(i_br_op);
  assign w_off   = w_waiting ? r_off   : i_br_offset;
  assign w_br_pc = w_waiting ? r_id_pc : i_id_pc;

  assign w_eval    = !i_rst && !i_stall_in && i_busA_ready && (w_waiting || i_br_valid);
  assign w_latch   = !w_waiting && i_br_valid && !i_busA_ready && !i_stall_in;
  assign w_taken   = w_eval && br_taken_f(w_op, i_zbgez, i_zbgtz);
  assign w_seq_adv = !i_stall_in && (w_eval || (!w_waiting && !i_br_valid));

  zero_branch_ctrl_br_target_calc u_target (
    .i_pc     (w_br_pc),
    .i_offset (w_off),
    .o_target (w_target)
  );

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_latch) w_state_next = StWait;
      StWait:  if (w_eval)  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // FSM outputs: one-hot judge select only in the evaluation cycle
  always_comb begin
    o_j_bgez   = 1'b0;
    o_j_bgtz   = 1'b0;
    o_j_blez   = 1'b0;
    o_j_bltz   = 1'b0;
    o_id_stall = w_waiting;
    if (w_eval) begin
      unique case (w_op)
        BR_BGEZ: o_j_bgez = 1'b1;
        BR_BGTZ: o_j_bgtz = 1'b1;
        BR_BLEZ: o_j_blez = 1'b1;
        BR_BLTZ: o_j_bltz = 1'b1;
        default: ;
      endcase
    end
  end

  // PC, latched branch fields, pulses and statistics
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc        <= RESET_PC;
      r_op        <= BR_BGEZ;
      r_off       <= '0;
      r_id_pc     <= '0;
      r_br_taken  <= 1'b0;
      r_flush_if  <= 1'b0;
      r_cnt_total <= '0;
      r_cnt_taken <= '0;
    end else begin
      r_br_taken <= w_taken;
      r_flush_if <= w_taken && (DELAY_SLOT == 1'b0);
      if (w_latch) begin
        r_op    <= br_op_e'(i_br_op);
        r_off   <= i_br_offset;
        r_id_pc <= i_id_pc;
      end
      if (w_taken) begin
        r_pc <= w_target;
      end else if (w_seq_adv) begin
        r_pc <= r_pc + 32'd4;
      end
      if (w_eval && (r_cnt_total != '1)) begin
        r_cnt_total <= r_cnt_total + CntOne;
      end
      if (w_taken && (r_cnt_taken != '1)) begin
        r_cnt_taken <= r_cnt_taken + CntOne;
      end
    end
  end

  assign o_j_busA    = i_busA;
  assign o_pc        = r_pc;
  assign o_br_taken  = r_br_taken;
  assign o_flush_if  = r_flush_if;
  assign o_cnt_total = r_cnt_total;
  assign o_cnt_taken = r_cnt_taken;

endmodule

// File: tb/tb_zero_branch_ctrl.sv
// Two controllers in lockstep: a delay-slot build with 16-bit counters and a flushing build
// with 4-bit counters (so saturation is reached quickly). A judge model answers the selects.
module tb_zero_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1, stall_in = 1'b0, br_valid = 1'b0, busA_ready = 1'b0;
  logic [1:0]  br_op = 2'b00;
  logic [15:0] br_offset = '0;
  logic [31:0] id_pc = '0, busA = '0;
  logic [1:0]  junk = '0;
  logic        zbgez, zbgtz;

  logic [31:0] a_jbus, a_pc, b_jbus, b_pc;
  logic        a_bgez, a_bgtz, a_blez, a_bltz, a_flush, a_stall, a_taken;
  logic        b_bgez, b_bgtz, b_blez, b_bltz, b_flush, b_stall, b_taken;
  logic [15:0] a_tot, a_tak;
  logic [3:0]  b_tot, b_tak;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Judge: real flags only while selected, garbage otherwise
  wire sel_any = a_bgez | a_bgtz | a_blez | a_bltz;
  assign zbgez = sel_any ? !busA[31]                    : junk[0];
  assign zbgtz = sel_any ? (!busA[31] && busA != 32'd0) : junk[1];

  zero_branch_ctrl #(.RESET_PC(32'h0000_3000), .DELAY_SLOT(1'b1), .CNT_W(16)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_stall_in(stall_in), .i_br_valid(br_valid), .i_br_op(br_op),
    .i_br_offset(br_offset), .i_id_pc(id_pc), .i_busA_ready(busA_ready), .i_busA(busA),
    .o_j_busA(a_jbus), .o_j_bgez(a_bgez), .o_j_bgtz(a_bgtz), .o_j_blez(a_blez),
    .o_j_bltz(a_bltz), .i_zbgez(zbgez), .i_zbgtz(zbgtz), .o_pc(a_pc), .o_flush_if(a_flush),
    .o_id_stall(a_stall), .o_br_taken(a_taken), .o_cnt_total(a_tot), .o_cnt_taken(a_tak)
  );

  zero_branch_ctrl #(.RESET_PC(32'h0000_3000), .DELAY_SLOT(1'b0), .CNT_W(4)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_stall_in(stall_in), .i_br_valid(br_valid), .i_br_op(br_op),
    .i_br_offset(br_offset), .i_id_pc(id_pc), .i_busA_ready(busA_ready), .i_busA(busA),
    .o_j_busA(b_jbus), .o_j_bgez(b_bgez), .o_j_bgtz(b_bgtz), .o_j_blez(b_blez),
    .o_j_bltz(b_bltz), .i_zbgez(zbgez), .i_zbgtz(zbgtz), .o_pc(b_pc), .o_flush_if(b_flush),
    .o_id_stall(b_stall), .o_br_taken(b_taken), .o_cnt_total(b_tot), .o_cnt_taken(b_tak)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] busa;
    logic [3:0]  sel;
    logic        taken_p;
    logic        flush_p;
    logic        stall;
    int          tot_a, tak_a, tot_b, tak_b;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  bit          m_known = 1'b0;
  bit          m_wait = 1'b0;
  logic [31:0] m_pc = '0;
  logic [1:0]  m_op = '0;
  logic [15:0] m_off = '0;
  logic [31:0] m_idpc = '0;
  bit          m_taken_p = 1'b0, m_flush_p = 1'b0;
  int          m_tot_a = 0, m_tak_a = 0, m_tot_b = 0, m_tak_b = 0;

  function automatic int sat_inc(input int v, input int maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  // Branch semantics on the signed value of rs
  function automatic bit ref_taken(input logic [1:0] op, input logic [31:0] a);
    int signed s;
    s = int'(a);
    case (op)
      2'd0:    return s >= 0;
      2'd1:    return s > 0;
      2'd2:    return s <= 0;
      default: return s < 0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit s, input bit v, input logic [1:0] op,
                      input logic [15:0] off, input logic [31:0] ipc, input bit rdy,
                      input logic [31:0] a);
    exp_t        e;
    bit          ev, tk;
    logic [1:0]  eop;
    logic [15:0] eoff;
    logic [31:0] epc, sx;
    @(posedge clk);
    #1;
    rst = r; stall_in = s; br_valid = v; br_op = op; br_offset = off; id_pc = ipc;
    busA_ready = rdy; busA = a; junk = 2'($urandom);
    ev   = !r && !s && rdy && (m_wait || v);
    eop  = m_wait ? m_op   : op;
    eoff = m_wait ? m_off  : off;
    epc  = m_wait ? m_idpc : ipc;
    if (m_known) begin
      e.pc = m_pc; e.busa = a; e.sel = ev ? (4'b0001 << eop) : 4'b0000;
      e.taken_p = m_taken_p; e.flush_p = m_flush_p; e.stall = m_wait;
      e.tot_a = m_tot_a; e.tak_a = m_tak_a; e.tot_b = m_tot_b; e.tak_b = m_tak_b;
      sb.push_back(e);
    end
    if (r) begin
      m_known = 1'b1; m_wait = 1'b0; m_pc = 32'h0000_3000; m_op = '0;
      m_taken_p = 1'b0; m_flush_p = 1'b0;
      m_tot_a = 0; m_tak_a = 0; m_tot_b = 0; m_tak_b = 0;
    end else begin
      m_taken_p = 1'b0; m_flush_p = 1'b0;
      if (!s) begin
        if (ev) begin
          tk = ref_taken(eop, a);
          sx = {{16{eoff[15]}}, eoff};
          m_pc = tk ? epc + 32'd4 + sx * 32'd4 : m_pc + 32'd4;
          m_taken_p = tk; m_flush_p = tk;
          m_tot_a = sat_inc(m_tot_a, 65535); m_tot_b = sat_inc(m_tot_b, 15);
          if (tk) begin
            m_tak_a = sat_inc(m_tak_a, 65535); m_tak_b = sat_inc(m_tak_b, 15);
          end
          m_wait = 1'b0;
        end else if (!m_wait && v) begin
          m_wait = 1'b1; m_op = op; m_off = off; m_idpc = ipc;
        end else if (!m_wait) begin
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  // Monitor: both builds present their state every cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pc_a", a_pc, e.pc);
        chk("pc_b", b_pc, e.pc);
        chk("j_busA", a_jbus, e.busa);
        chk("sel_a", {28'd0, a_bltz, a_blez, a_bgtz, a_bgez}, {28'd0, e.sel});
        chk("sel_b", {28'd0, b_bltz, b_blez, b_bgtz, b_bgez}, {28'd0, e.sel});
        chk("br_taken_a", {31'd0, a_taken}, {31'd0, e.taken_p});
        chk("br_taken_b", {31'd0, b_taken}, {31'd0, e.taken_p});
        chk("flush_a", {31'd0, a_flush}, 32'd0);
        chk("flush_b", {31'd0, b_flush}, {31'd0, e.flush_p});
        chk("id_stall_a", {31'd0, a_stall}, {31'd0, e.stall});
        chk("id_stall_b", {31'd0, b_stall}, {31'd0, e.stall});
        chk("cnt_total_a", {16'd0, a_tot}, 32'(e.tot_a));
        chk("cnt_taken_a", {16'd0, a_tak}, 32'(e.tak_a));
        chk("cnt_total_b", {28'd0, b_tot}, 32'(e.tot_b));
        chk("cnt_taken_b", {28'd0, b_tak}, 32'(e.tak_b));
      end
    end
  end

  initial begin
    logic [31:0] a;
    step(1, 0, 0, 2'd0, 16'h0, 32'h0, 0, 32'h0);
    step(1, 0, 0, 2'd0, 16'h0, 32'h0, 0, 32'h0);
    step(0, 0, 0, 2'd0, 16'h0, 32'h0, 0, 32'h0);
    // bgez on zero, taken to 0x3014
    step(0, 0, 1, 2'd0, 16'h0004, 32'h3000, 1, 32'h0);
    step(0, 0, 0, 2'd0, 16'h0, 32'h0, 0, 32'h0);
    // bltz on -1 with offset -1, taken to itself
    step(0, 0, 1, 2'd3, 16'hFFFF, 32'h3010, 1, 32'hFFFF_FFFF);
    // back-to-back: bgtz on zero, not taken
    step(0, 0, 1, 2'd1, 16'h0010, 32'h3014, 1, 32'h0);
    // blez waits three cycles while br_op wanders, then rs=5: not taken
    step(0, 0, 1, 2'd2, 16'h0020, 32'h3018, 0, 32'h0);
    step(0, 0, 1, 2'd0, 16'h0040, 32'h3100, 0, 32'h0);
    step(0, 0, 1, 2'd3, 16'h0080, 32'h3200, 0, 32'h0);
    step(0, 0, 1, 2'd0, 16'h0100, 32'h3300, 1, 32'h5);
    // freeze during an otherwise ready branch, then release
    step(0, 1, 1, 2'd2, 16'h0008, 32'h3040, 1, 32'h0);
    step(0, 1, 1, 2'd2, 16'h0008, 32'h3040, 1, 32'h0);
    step(0, 0, 1, 2'd2, 16'h0008, 32'h3040, 1, 32'h0);
    // freeze while waiting, then reset mid-wait
    step(0, 0, 1, 2'd0, 16'h0008, 32'h3050, 0, 32'h0);
    step(0, 1, 0, 2'd0, 16'h0, 32'h0, 1, 32'h0);
    step(1, 0, 0, 2'd0, 16'h0, 32'h0, 1, 32'h0);
    step(0, 0, 0, 2'd0, 16'h0, 32'h0, 1, 32'h0);
    // target wraps through zero
    step(0, 0, 1, 2'd0, 16'h0001, 32'hFFFF_FFF8, 1, 32'h7);
    step(0, 0, 0, 2'd0, 16'h0, 32'h0, 0, 32'h0);
    for (int i = 0; i < 500; i++) begin
      case ($urandom_range(0, 3))
        0:       a = 32'h0;
        1:       a = $urandom;
        2:       a = 32'($urandom_range(1, 20));
        default: a = 32'hFFFF_FFFF;
      endcase
      step(($urandom_range(0, 79) == 0), ($urandom_range(0, 6) == 0),
           bit'($urandom_range(0, 1)), 2'($urandom), 16'($urandom), $urandom,
           ($urandom_range(0, 3) != 0), a);
    end
    step(0, 0, 0, 2'd0, 16'h0, 32'h0, 0, 32'h0);
    repeat (2) @(negedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
